// File: rtl/countdown_mmss_pkg.sv
// rtl/countdown_mmss_pkg.sv - shared state encoding, digit limits and time record for the mm:ss countdown
package countdown_mmss_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RUN    = 2'd1,
    ST_PAUSED = 2'd2,
    ST_DONE   = 2'd3
  } state_t;

  localparam logic [3:0] BCD_MAX      = 4'd9;
  localparam logic [3:0] SEC_TENS_MAX = 4'd5;

  typedef struct packed {
    logic [3:0] m1;
    logic [3:0] m0;
    logic [3:0] s1;
    logic [3:0] s0;
  } bcd_time_t;

endpackage

// File: rtl/countdown_mmss_bcd_digit_dec.sv
// rtl/countdown_mmss_bcd_digit_dec.sv - one BCD digit of the borrow chain
module bcd_digit_dec #(
  parameter logic [3:0] MAX_DIGIT = 4'd9
) (
  input  logic [3:0] digit,
  input  logic       borrow_in,
  output logic [3:0] next_digit,
  output logic       borrow_out
);

  always_comb begin
    next_digit = digit;
    borrow_out = 1'b0;
    if (borrow_in) begin
      if (digit == 4'd0) begin
        next_digit = MAX_DIGIT;
        borrow_out = 1'b1;
      end else begin
        next_digit = digit - 4'd1;
      end
    end
  end

endmodule

// File: rtl/countdown_mmss.sv
// rtl/countdown_mmss.sv - mm:ss BCD countdown timer with preset load, pause and optional auto reload
module countdown_mmss
  import countdown_mmss_pkg::*;
#(
  parameter int AUTO_RELOAD  = 0,
  parameter int MIN_TENS_MAX = 5
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       tick,
  input  logic       load,
  input  logic       start,
  input  logic       pauza,
  input  logic [3:0] in_bcd1_m,
  input  logic [3:0] in_bcd0_m,
  input  logic [3:0] in_bcd1_s,
  input  logic [3:0] in_bcd0_s,
  output logic [3:0] bcd1_m,
  output logic [3:0] bcd0_m,
  output logic [3:0] bcd1_s,
  output logic [3:0] bcd0_s,
  output logic       running,
  output logic       done,
  output logic       load_err
);

  state_t    state;
  bcd_time_t value;
  bcd_time_t preset;
  bcd_time_t in_time;
  bcd_time_t dec;
  logic      b_s0, b_s1, b_m0, b_m1;
  logic      load_ok;
  logic      dec_zero;

  assign in_time = {in_bcd1_m, in_bcd0_m, in_bcd1_s, in_bcd0_s};

  assign load_ok = (in_bcd0_s <= BCD_MAX) && (in_bcd1_s <= SEC_TENS_MAX) &&
                   (in_bcd0_m <= BCD_MAX) && (in_bcd1_m <= 4'(MIN_TENS_MAX));

  // Seconds units always borrow; each stage passes its borrow up the chain.
  bcd_digit_dec #(.MAX_DIGIT(BCD_MAX)) u_s0 (
    .digit(value.s0), .borrow_in(1'b1), .next_digit(dec.s0), .borrow_out(b_s0)
  );
  bcd_digit_dec #(.MAX_DIGIT(SEC_TENS_MAX)) u_s1 (
    .digit(value.s1), .borrow_in(b_s0), .next_digit(dec.s1), .borrow_out(b_s1)
  );
  bcd_digit_dec #(.MAX_DIGIT(BCD_MAX)) u_m0 (
    .digit(value.m0), .borrow_in(b_s1), .next_digit(dec.m0), .borrow_out(b_m0)
  );
  bcd_digit_dec #(.MAX_DIGIT(4'(MIN_TENS_MAX))) u_m1 (
    .digit(value.m1), .borrow_in(b_m0), .next_digit(dec.m1), .borrow_out(b_m1)
  );

  assign dec_zero = (dec == '0);

  always_ff @(posedge clock) begin
    if (reset) begin
      state    <= ST_IDLE;
      value    <= '0;
      preset   <= '0;
      done     <= 1'b0;
      load_err <= 1'b0;
    end else begin
      done     <= 1'b0;
      load_err <= 1'b0;
      if (load) begin
        if (load_ok) begin
          value  <= in_time;
          preset <= in_time;
          state  <= ST_IDLE;
        end else begin
          load_err <= 1'b1;
        end
      end else begin
        case (state)
          ST_IDLE: begin
            if (!pauza && start && (value != '0))
              state <= ST_RUN;
          end
          ST_RUN: begin
            if (pauza) begin
              state <= ST_PAUSED;
            end else if (tick) begin
              // A full borrow out of the top digit means we sit at 00:00 after an auto-reload done.
              if (b_m1) begin
                value <= preset;
              end else begin
                value <= dec;
                if (dec_zero) begin
                  done <= 1'b1;
                  if (AUTO_RELOAD == 0)
                    state <= ST_DONE;
                end
              end
            end
          end
          ST_PAUSED: begin
            if (!pauza)
              state <= ST_RUN;
          end
          default: ;
        endcase
      end
    end
  end

  assign running = (state == ST_RUN);
  assign bcd1_m  = value.m1;
  assign bcd0_m  = value.m0;
  assign bcd1_s  = value.s1;
  assign bcd0_s  = value.s0;

endmodule

// File: tb/tb_countdown_mmss.sv
// tb/tb_countdown_mmss.sv - bench for countdown_mmss, plain and auto-reload variants side by side
module tb_countdown_mmss;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       tick = 1'b0, load = 1'b0, start = 1'b0, pauza = 1'b0;
  logic [3:0] in_bcd1_m = '0, in_bcd0_m = '0, in_bcd1_s = '0, in_bcd0_s = '0;

  logic [3:0] a1m, a0m, a1s, a0s, b1m, b0m, b1s, b0s;
  logic       run0, done0, err0, run1, done1, err1;
  logic [15:0] v0, v1;

  int  checks = 0;
  int  errors = 0;
  bit  armed = 1'b0;

  // Model state per variant: value and preset in plain seconds, state 0 idle 1 run 2 paused 3 done
  int  m_val[2], m_pre[2], m_st[2];
  bit  m_done[2], m_err[2];

  always #5 clock = ~clock;

  countdown_mmss #(.AUTO_RELOAD(0), .MIN_TENS_MAX(5)) dut0 (
    .clock(clock), .reset(reset), .tick(tick), .load(load), .start(start), .pauza(pauza),
    .in_bcd1_m(in_bcd1_m), .in_bcd0_m(in_bcd0_m), .in_bcd1_s(in_bcd1_s), .in_bcd0_s(in_bcd0_s),
    .bcd1_m(a1m), .bcd0_m(a0m), .bcd1_s(a1s), .bcd0_s(a0s),
    .running(run0), .done(done0), .load_err(err0)
  );

  countdown_mmss #(.AUTO_RELOAD(1), .MIN_TENS_MAX(5)) dut1 (
    .clock(clock), .reset(reset), .tick(tick), .load(load), .start(start), .pauza(pauza),
    .in_bcd1_m(in_bcd1_m), .in_bcd0_m(in_bcd0_m), .in_bcd1_s(in_bcd1_s), .in_bcd0_s(in_bcd0_s),
    .bcd1_m(b1m), .bcd0_m(b0m), .bcd1_s(b1s), .bcd0_s(b0s),
    .running(run1), .done(done1), .load_err(err1)
  );

  assign v0 = {a1m, a0m, a1s, a0s};
  assign v1 = {b1m, b0m, b1s, b0s};

  function automatic logic [15:0] to_bcd(int s);
    return {4'(s / 600), 4'((s / 60) % 10), 4'((s % 60) / 10), 4'(s % 10)};
  endfunction

  function automatic logic [18:0] expect_of(int k);
    return {to_bcd(m_val[k]), m_st[k] == 1, m_done[k], m_err[k]};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic model_step(input int k);
    int  mm, ss;
    bit  ok;
    m_done[k] = 1'b0;
    m_err[k]  = 1'b0;
    mm = int'(in_bcd1_m) * 10 + int'(in_bcd0_m);
    ss = int'(in_bcd1_s) * 10 + int'(in_bcd0_s);
    ok = (in_bcd1_m <= 5) && (in_bcd0_m <= 9) && (in_bcd1_s <= 5) && (in_bcd0_s <= 9);
    if (reset) begin
      m_val[k] = 0; m_pre[k] = 0; m_st[k] = 0;
    end else if (load) begin
      if (ok) begin
        m_val[k] = mm * 60 + ss; m_pre[k] = m_val[k]; m_st[k] = 0;
      end else begin
        m_err[k] = 1'b1;
      end
    end else if (m_st[k] == 0) begin
      if (!pauza && start && m_val[k] > 0) m_st[k] = 1;
    end else if (m_st[k] == 1) begin
      if (pauza) m_st[k] = 2;
      else if (tick) begin
        if (m_val[k] == 0) m_val[k] = m_pre[k];
        else begin
          m_val[k] = m_val[k] - 1;
          if (m_val[k] == 0) begin
            m_done[k] = 1'b1;
            if (k == 0) m_st[k] = 3;
          end
        end
      end
    end else if (m_st[k] == 2) begin
      if (!pauza) m_st[k] = 1;
    end
  endtask

  always @(posedge clock) begin
    for (int k = 0; k < 2; k++) model_step(k);
    #1;
    if (armed) begin
      chk("cycle_plain", {13'd0, v0, run0, done0, err0}, {13'd0, expect_of(0)});
      chk("cycle_auto", {13'd0, v1, run1, done1, err1}, {13'd0, expect_of(1)});
    end
  end

  task automatic cyc(input bit t, input bit l, input bit s, input bit p, input logic [15:0] d);
    @(negedge clock);
    reset = 1'b0; tick = t; load = l; start = s; pauza = p;
    {in_bcd1_m, in_bcd0_m, in_bcd1_s, in_bcd0_s} = d;
    @(posedge clock);
    #2;
  endtask

  task automatic rst_cyc();
    @(negedge clock);
    reset = 1'b1; tick = 1'b0; load = 1'b0; start = 1'b0; pauza = 1'b0;
    @(posedge clock);
    #2;
  endtask

  initial begin
    for (int k = 0; k < 2; k++) begin
      m_val[k] = 0; m_pre[k] = 0; m_st[k] = 0; m_done[k] = 0; m_err[k] = 0;
    end
    rst_cyc();
    armed = 1'b1;
    rst_cyc();
    chk("reset_value", v0, 16'h0000);
    chk("reset_running", run0, 0);
    chk("reset_done", done0, 0);

    // 01:00 down to 00:00
    cyc(0, 1, 0, 0, 16'h0100);
    chk("load_0100", v0, 16'h0100);
    cyc(0, 0, 1, 0, 16'h0000);
    chk("start_running", run0, 1);
    for (int i = 1; i <= 60; i++) begin
      cyc(1, 0, 0, 0, 16'h0000);
      if (i == 1)  chk("tick1_0059", v0, 16'h0059);
      if (i == 10) chk("tick10_0050", v0, 16'h0050);
    end
    chk("tick60_value", v0, 16'h0000);
    chk("tick60_done", done0, 1);
    chk("tick60_state_done", run0, 0);
    chk("tick60_auto_running", run1, 1);
    cyc(0, 0, 0, 0, 16'h0000);
    chk("done_one_cycle", done0, 0);
    cyc(1, 0, 1, 0, 16'h0000);
    chk("done_ignores_tick", v0, 16'h0000);
    chk("done_ignores_start", run0, 0);

    // triple borrow and rejected presets
    cyc(0, 1, 0, 0, 16'h1000);
    cyc(0, 0, 1, 0, 16'h0000);
    cyc(1, 0, 0, 0, 16'h0000);
    chk("borrow_0959", v0, 16'h0959);
    cyc(0, 1, 0, 0, 16'h075A);
    chk("bad_load_err", err0, 1);
    chk("bad_load_keep", v0, 16'h0959);
    cyc(0, 0, 0, 0, 16'h0000);
    chk("bad_load_err_pulse", err0, 0);
    chk("bad_load_still_run", run0, 1);
    cyc(0, 1, 0, 0, 16'h6000);
    chk("bad_min_tens", err0, 1);
    cyc(0, 1, 0, 0, 16'h0060);
    chk("bad_sec_tens", err0, 1);
    chk("bad_keep_again", v0, 16'h0959);
    cyc(0, 1, 0, 0, 16'h5959);
    cyc(0, 0, 1, 0, 16'h0000);
    cyc(1, 0, 0, 0, 16'h0000);
    chk("max_5958", v0, 16'h5958);

    // pause holds through ticks
    cyc(0, 1, 0, 0, 16'h0031);
    cyc(0, 0, 1, 0, 16'h0000);
    cyc(1, 0, 0, 0, 16'h0000);
    chk("pause_pre_0030", v0, 16'h0030);
    for (int i = 0; i < 3; i++) cyc(1, 0, 0, 1, 16'h0000);
    chk("paused_hold", v0, 16'h0030);
    chk("paused_not_running", run0, 0);
    cyc(0, 0, 0, 0, 16'h0000);
    chk("resume_running", run0, 1);
    cyc(1, 0, 0, 0, 16'h0000);
    chk("resume_0029", v0, 16'h0029);

    // load wins over start and tick; start at zero does nothing
    cyc(1, 1, 1, 0, 16'h0200);
    chk("load_wins_value", v0, 16'h0200);
    chk("load_wins_idle", run0, 0);
    cyc(0, 1, 0, 0, 16'h0000);
    cyc(0, 0, 1, 0, 16'h0000);
    chk("zero_start_no_done", done0, 0);
    chk("zero_start_idle", run0, 0);

    // auto reload
    cyc(0, 1, 0, 0, 16'h0002);
    cyc(0, 0, 1, 0, 16'h0000);
    cyc(1, 0, 0, 0, 16'h0000);
    cyc(1, 0, 0, 0, 16'h0000);
    chk("auto_zero", v1, 16'h0000);
    chk("auto_done", done1, 1);
    chk("auto_running", run1, 1);
    cyc(1, 0, 0, 0, 16'h0000);
    chk("auto_reload_0002", v1, 16'h0002);
    chk("auto_reload_running", run1, 1);
    chk("plain_stays_zero", v0, 16'h0000);

    // reset mid-count
    cyc(0, 1, 0, 0, 16'h0006);
    cyc(0, 0, 1, 0, 16'h0000);
    cyc(1, 0, 0, 0, 16'h0000);
    chk("pre_reset_0005", v0, 16'h0005);
    rst_cyc();
    chk("abort_value", v0, 16'h0000);
    chk("abort_idle", run0, 0);
    chk("abort_no_done", done0, 0);
    cyc(1, 0, 0, 0, 16'h0000);
    chk("abort_no_done_later", done0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
